// File: rtl/ras.sv
// Return address stack for the fetch predictor: call pushes, return pops, coroutine swaps top.
// Top/count are exported as a checkpoint and can be restored by the backend on mispredict.
module ras #(
   parameter int RAS_ENTRIES      = 8,
   parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
   parameter int RAS_TARGET_WIDTH = 31
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        link_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] link_target,
   input  logic                        ret_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ret_target,
   output logic                        ret_hit,
   output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
   output logic [RAS_INDEX_WIDTH:0]    ras_count,
   input  logic                        update_valid,
   input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
   input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);

   localparam logic [RAS_INDEX_WIDTH:0]   COUNT_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
   localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE    = RAS_INDEX_WIDTH'(1);
   localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE    = (RAS_INDEX_WIDTH+1)'(1);

   logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
   logic [RAS_INDEX_WIDTH-1:0]  top;
   logic [RAS_INDEX_WIDTH:0]    count;

   logic [RAS_INDEX_WIDTH-1:0]  top_nxt;
   logic [RAS_INDEX_WIDTH:0]    count_nxt;
   logic                        wr_en;
   logic [RAS_INDEX_WIDTH-1:0]  wr_idx;

   assign ret_target = stack[top];
   assign ret_hit    = (count != '0);
   assign ras_index  = top;
   assign ras_count  = count;

   always_comb begin
      top_nxt   = top;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_idx    = top;
      if (update_valid) begin
         top_nxt   = update_ras_index;
         count_nxt = update_ras_count;
      end else if (link_valid && ret_valid) begin
         // coroutine: replace the return target in place
         wr_en  = 1'b1;
         wr_idx = top;
      end else if (link_valid) begin
         top_nxt   = top + IDX_ONE;
         wr_en     = 1'b1;
         wr_idx    = top + IDX_ONE;
         count_nxt = (count == COUNT_FULL) ? count : count + CNT_ONE;
      end else if (ret_valid) begin
         // underflow still moves the pointer so later pushes stay aligned
         top_nxt   = top - IDX_ONE;
         count_nxt = (count == '0) ? count : count - CNT_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         top   <= '0;
         count <= '0;
         for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= '0;
      end else begin
         top   <= top_nxt;
         count <= count_nxt;
         if (wr_en) stack[wr_idx] <= link_target;
         if (update_valid)
            assert (update_ras_count <= COUNT_FULL)
               else $error("ras: restored count %0d exceeds depth", update_ras_count);
      end
   end

endmodule
